instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: 2-entry {instr, pc} buffer with one in-flight ROM read.
// Define FETCH_HALT_EN to stop issuing after an all-ones (halt) word is fetched.
module instruction_fetch #(
    parameter int IW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_in,
    output logic          pc_en,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [IW-1:0] mem_data,
    input  logic          flush,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          halted
);

    logic [1:0]    r_count;
    logic          r_inflight;
    logic [AW-1:0] r_tag;
    logic [IW-1:0] r_data [2];
    logic [AW-1:0] r_pc   [2];

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic          w_halted;
    logic [2:0]    w_occ;
    logic [1:0]    w_base;
    logic [IW-1:0] w_data_n [2];
    logic [AW-1:0] w_pc_n   [2];

    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_data[0];
    assign instr_pc    = r_pc[0];

    assign w_pop  = instr_valid && instr_ready;
    assign w_push = r_inflight && !flush;
    assign w_occ  = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};

    // Occupancy counts the in-flight read, so the buffer can never overflow.
    assign w_issue  = !rst && !flush && !w_halted && (w_occ < 3'd2);
    assign pc_en    = w_issue;
    assign mem_rd   = w_issue;
    assign mem_addr = pc_in;
    assign halted   = w_halted;

    always_comb begin
        w_data_n = r_data;
        w_pc_n   = r_pc;
        w_base   = r_count - {1'b0, w_pop};
        if (w_pop && (r_count == 2'd2)) begin
            w_data_n[0] = r_data[1];
            w_pc_n[0]   = r_pc[1];
        end
        // A pop from a single entry keeps the head so outputs hold when empty.
        if (w_push) begin
            if (w_base == 2'd0) begin
                w_data_n[0] = mem_data;
                w_pc_n[0]   = r_tag;
            end else begin
                w_data_n[1] = mem_data;
                w_pc_n[1]   = r_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_data[0]  <= '0;
            r_data[1]  <= '0;
            r_pc[0]    <= '0;
            r_pc[1]    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= pc_in;
            end
            if (flush) begin
                r_count <= 2'd0;
            end else begin
                r_count <= w_base + {1'b0, w_push};
                r_data  <= w_data_n;
                r_pc    <= w_pc_n;
            end
        end
    end

`ifdef FETCH_HALT_EN
    logic r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_push && (mem_data == {IW{1'b1}})) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a synchronous ROM and PC model.
// Halt expectations follow FETCH_HALT_EN.
module tb_instruction_fetch;

    localparam int IW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] pc_rst_val = '0;
    logic          pc_en;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [IW-1:0] mem_data = '0;
    logic          flush = 1'b0;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          halted;
    bit            rom_halt = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.IW(IW), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .pc_in(pc),
        .pc_en(pc_en),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .flush(flush),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .halted(halted)
    );

    function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
        if (rom_halt && (a == 6'd3)) return '1;
        return 32'h100 + {26'b0, a};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) pc <= pc_rst_val;
        else if (pc_en) pc <= pc + 1'b1;
    end

    always @(posedge clk) begin
        if (mem_rd) mem_data <= rom(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic head(input string tag, input int p);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, {26'b0, instr_pc}, p);
        chk({tag, "_instr"}, instr, 32'h100 + p);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", {26'b0, instr_pc}, 0);
        chk("rst_pcen", {31'b0, pc_en}, 0);
        chk("rst_halted", {31'b0, halted}, 0);

        // Streaming with decode always ready
        rst = 1'b0;
        instr_ready = 1'b1;
        #1 chk("first_issue", {31'b0, pc_en}, 1);
        @(negedge clk);
        chk("lat_valid", {31'b0, instr_valid}, 0);
        @(negedge clk);
        head("s0", 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            head("stream", k);
        end

        // Back-pressure: head pc 5 held, buffer fills, fetch stops
        instr_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_pcen", {31'b0, pc_en}, 0);
            head("bp", 5);
        end
        instr_ready = 1'b1;
        #1 chk("bp_rel_pcen", {31'b0, pc_en}, 1);
        @(negedge clk);
        head("rel6", 6);
        @(negedge clk);
        head("rel7", 7);
        @(negedge clk);
        head("rel8", 8);

        // Flush with pc 8 buffered and pc 9 in flight
        flush = 1'b1;
        instr_ready = 1'b0;
        #1 chk("flush_pcen", {31'b0, pc_en}, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", {31'b0, instr_valid}, 0);
        chk("flush_hold_pc", {26'b0, instr_pc}, 8);
        #1 chk("flush_resume", {31'b0, pc_en}, 1);
        chk("flush_addr", {26'b0, mem_addr}, 10);
        @(negedge clk);
        chk("flush_lat", {31'b0, instr_valid}, 0);
        @(negedge clk);
        head("after_flush", 10);

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 0);
        chk("arst_instr", instr, 0);
        chk("arst_pc", {26'b0, instr_pc}, 0);
        chk("arst_pcen", {31'b0, pc_en}, 0);
        @(negedge clk);
        rst = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("arst_lat", {31'b0, instr_valid}, 0);
        @(negedge clk);
        head("restart0", 0);
        @(negedge clk);
        head("restart1", 1);

        // PC wrap-around 62, 63, 0, 1
        pc_rst_val = 6'd62;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        head("wrap62", 62);
        @(negedge clk);
        head("wrap63", 63);
        @(negedge clk);
        head("wrap0", 0);
        @(negedge clk);
        head("wrap1", 1);

        // All-ones word at address 3
        pc_rst_val = 6'd0;
        rom_halt = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        head("h0", 0);
        @(negedge clk);
        head("h1", 1);
        @(negedge clk);
        head("h2", 2);
        @(negedge clk);
        chk("h3_valid", {31'b0, instr_valid}, 1);
        chk("h3_pc", {26'b0, instr_pc}, 3);
        chk("h3_instr", instr, 32'hFFFF_FFFF);
`ifdef FETCH_HALT_EN
        chk("h3_halted", {31'b0, halted}, 1);
        chk("h3_pcen", {31'b0, pc_en}, 0);
        @(negedge clk);
        head("h4", 4);
        chk("h4_pcen", {31'b0, pc_en}, 0);
        @(negedge clk);
        chk("h_drained", {31'b0, instr_valid}, 0);
        chk("h_pcen", {31'b0, pc_en}, 0);
        chk("h_sticky", {31'b0, halted}, 1);
        rst = 1'b1;
        #1 chk("h_rst_clear", {31'b0, halted}, 0);
`else
        chk("h3_halted", {31'b0, halted}, 0);
        chk("h3_pcen", {31'b0, pc_en}, 1);
        @(negedge clk);
        head("h4", 4);
        @(negedge clk);
        head("h5", 5);
        chk("h5_halted", {31'b0, halted}, 0);
        rst = 1'b1;
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
